iccm_port_arb: RTL and testbench

ICCM_PORT_ARB -- requirements
Module: iccm_port_arb

---
 rtl/iccm_arb_pkg.sv | 17 +
 rtl/iccm_port_arb_if.sv | 48 ++++
 rtl/iccm_wr_fifo.sv | 46 ++++
 rtl/iccm_port_arb.sv | 160 ++++++++++++++++
 tb/tb_iccm_port_arb.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iccm_arb_pkg.sv
// Shared types and defaults for the ICCM port arbiter.
package iccm_arb_pkg;

  // Default depth of the programmer write buffer
  localparam int WDEPTH_DEFAULT = 2;

  // Write-enable mask used for every programmer (FIFO) write
  localparam logic [3:0] FULL_WMASK = 4'hF;

  // Arbiter operating modes
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROG  = 2'd1,
    DRAIN = 2'd2
  } arbState_t;

endpackage

// File: rtl/iccm_port_arb_if.sv
// Bundles the loader, host and SRAM-side signals of the ICCM port arbiter.
interface iccm_port_arb_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          prog_i;
  logic          pw_we_i;
  logic [AW-1:0] pw_addr_i;
  logic [DW-1:0] pw_wdata_i;

  logic          h_req_i;
  logic          h_we_i;
  logic [AW-1:0] h_addr_i;
  logic [DW-1:0] h_wdata_i;
  logic [3:0]    h_wmask_i;
  logic          h_gnt_o;
  logic          h_rvalid_o;
  logic [DW-1:0] h_rdata_o;

  logic          csb_o;
  logic          web_o;
  logic [3:0]    wmask_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] rdata_i;

  logic          busy_o;
  logic          ovf_o;
  logic [AW:0]   wr_cnt_o;

  modport slave (
    input  prog_i, pw_we_i, pw_addr_i, pw_wdata_i,
    input  h_req_i, h_we_i, h_addr_i, h_wdata_i, h_wmask_i,
    output h_gnt_o, h_rvalid_o, h_rdata_o,
    output csb_o, web_o, wmask_o, addr_o, wdata_o,
    input  rdata_i,
    output busy_o, ovf_o, wr_cnt_o
  );

  modport master (
    output prog_i, pw_we_i, pw_addr_i, pw_wdata_i,
    output h_req_i, h_we_i, h_addr_i, h_wdata_i, h_wmask_i,
    input  h_gnt_o, h_rvalid_o, h_rdata_o,
    input  csb_o, web_o, wmask_o, addr_o, wdata_o,
    output rdata_i,
    input  busy_o, ovf_o, wr_cnt_o
  );
endinterface

// File: rtl/iccm_wr_fifo.sv
// Small circular FIFO buffering programmer writes; a push while full is
// only taken when a pop frees the head slot in the same cycle.
module iccm_wr_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wrPtr;
  logic [PW:0]      r_rdPtr;
  logic             w_write;
  logic             w_read;

  assign empty_o = (r_wrPtr == r_rdPtr);
  assign full_o  = (r_wrPtr[PW] != r_rdPtr[PW]) &&
                   (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);
  assign w_read  = pop_i && !empty_o;
  assign w_write = push_i && (!full_o || w_read);
  assign head_o  = r_mem[r_rdPtr[PW-1:0]];

  // Pointer bookkeeping; reset simply forgets everything buffered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_write) r_wrPtr <= r_wrPtr + (PW+1)'(1);
      if (w_read)  r_rdPtr <= r_rdPtr + (PW+1)'(1);
    end
  end

  // Storage needs no reset since the pointers mark it empty
  always_ff @(posedge clk_i) begin
    if (w_write) r_mem[r_wrPtr[PW-1:0]] <= data_i;
  end
endmodule

// File: rtl/iccm_port_arb.sv
// Shares one single-port ICCM SRAM between the host bus and the UART boot
// loader, buffering loader writes and arbitrating round-robin when idle.
module iccm_port_arb
  import iccm_arb_pkg::*;
#(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int WDEPTH = WDEPTH_DEFAULT
) (
  input logic            clk_i,
  input logic            rst_i,
  iccm_port_arb_if.slave bus
);
  arbState_t     r_state;
  arbState_t     w_nextState;
  logic          w_fifoFull;
  logic          w_fifoEmpty;
  logic [AW+DW-1:0] w_head;
  logic [AW-1:0] w_headAddr;
  logic [DW-1:0] w_headData;
  logic          w_pop;
  logic          w_hostGnt;
  logic          r_lastFifo;
  logic          r_armed;
  logic          r_rvalid;
  logic          r_ovf;
  logic [AW:0]   r_wrCnt;
  logic [AW-1:0] r_addrHold;
  logic [DW-1:0] r_wdataHold;
  logic [3:0]    r_wmaskHold;

  iccm_wr_fifo #(
    .WIDTH (AW+DW),
    .DEPTH (WDEPTH)
  ) u_wrFifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (bus.pw_we_i),
    .pop_i   (w_pop),
    .data_i  ({bus.pw_addr_i, bus.pw_wdata_i}),
    .head_o  (w_head),
    .full_o  (w_fifoFull),
    .empty_o (w_fifoEmpty)
  );

  assign w_headAddr = w_head[AW+DW-1:DW];
  assign w_headData = w_head[DW-1:0];

  // Mode register plus one-cycle post-reset guard that blocks SRAM access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_armed <= 1'b1;
    end
  end

  // Mode transitions; a returning prog request wins over finishing the drain
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.prog_i) w_nextState = PROG;
      PROG:    if (!bus.prog_i) w_nextState = DRAIN;
      DRAIN: begin
        if (bus.prog_i)       w_nextState = PROG;
        else if (w_fifoEmpty) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Pick this cycle's SRAM user; the loader owns the port outside IDLE
  always_comb begin
    w_pop     = 1'b0;
    w_hostGnt = 1'b0;
    if (r_armed) begin
      if (r_state == IDLE) begin
        if (bus.h_req_i && !w_fifoEmpty) begin
          if (r_lastFifo) w_hostGnt = 1'b1;
          else            w_pop     = 1'b1;
        end else if (bus.h_req_i) begin
          w_hostGnt = 1'b1;
        end else if (!w_fifoEmpty) begin
          w_pop = 1'b1;
        end
      end else begin
        w_pop = !w_fifoEmpty;
      end
    end
  end

  // SRAM port mux; address/data/mask keep their previous value when unused
  always_comb begin
    bus.csb_o   = 1'b1;
    bus.web_o   = 1'b1;
    bus.addr_o  = r_addrHold;
    bus.wdata_o = r_wdataHold;
    bus.wmask_o = r_wmaskHold;
    if (w_hostGnt) begin
      bus.csb_o   = 1'b0;
      bus.web_o   = ~bus.h_we_i;
      bus.addr_o  = bus.h_addr_i;
      bus.wdata_o = bus.h_wdata_i;
      bus.wmask_o = bus.h_wmask_i;
    end else if (w_pop) begin
      bus.csb_o   = 1'b0;
      bus.web_o   = 1'b0;
      bus.addr_o  = w_headAddr;
      bus.wdata_o = w_headData;
      bus.wmask_o = FULL_WMASK;
    end
  end

  // Remember the last driven SRAM address/data/mask for idle cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addrHold  <= '0;
      r_wdataHold <= '0;
      r_wmaskHold <= '0;
    end else if (w_hostGnt || w_pop) begin
      r_addrHold  <= bus.addr_o;
      r_wdataHold <= bus.wdata_o;
      r_wmaskHold <= bus.wmask_o;
    end
  end

  // Round-robin memory: only contention-capable IDLE grants move the pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                  r_lastFifo <= 1'b0;
    else if (r_state == IDLE && (w_hostGnt || w_pop)) r_lastFifo <= w_pop;
  end

  // Read data from the SRAM arrives one cycle after a host read grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_rvalid <= 1'b0;
    else       r_rvalid <= w_hostGnt && !bus.h_we_i;
  end

  // Sticky flag for a loader write that found no room
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                        r_ovf <= 1'b0;
    else if (bus.pw_we_i && w_fifoFull && !w_pop)     r_ovf <= 1'b1;
  end

  // Saturating count of committed loader writes, restarted per programming session
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                      r_wrCnt <= '0;
    else if (r_state == IDLE && w_nextState == PROG) r_wrCnt <= '0;
    else if (w_pop && (r_wrCnt != {(AW+1){1'b1}}))  r_wrCnt <= r_wrCnt + (AW+1)'(1);
  end

  assign bus.h_gnt_o    = w_hostGnt;
  assign bus.h_rvalid_o = r_rvalid;
  assign bus.h_rdata_o  = bus.rdata_i;
  assign bus.busy_o     = (r_state != IDLE) || !w_fifoEmpty;
  assign bus.ovf_o      = r_ovf;
  assign bus.wr_cnt_o   = r_wrCnt;
endmodule

// File: tb/tb_iccm_port_arb.sv
// Self-checking bench for iccm_port_arb: directed scenarios followed by a
// random phase, all compared each cycle against a behavioural model.
module tb_iccm_port_arb;
  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int WDEPTH = 2;
  localparam int CNT_MAX = (1 << (AW+1)) - 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  iccm_port_arb_if #(.AW(AW), .DW(DW)) bus ();

  iccm_port_arb #(.AW(AW), .DW(DW), .WDEPTH(WDEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM with one-cycle read latency and byte mask
  logic [31:0] sramMem [4096];
  always @(posedge clk) begin
    if (bus.csb_o === 1'b0) begin
      if (bus.web_o === 1'b0) begin
        for (int b = 0; b < 4; b++)
          if (bus.wmask_o[b]) sramMem[bus.addr_o][8*b +: 8] <= bus.wdata_o[8*b +: 8];
      end else begin
        bus.rdata_i <= sramMem[bus.addr_o];
      end
    end
  end

  // Reference model state, kept in terms of the requirements not the RTL
  logic [31:0] refMem [4096];
  logic [11:0] qAddr[$];
  logic [31:0] qData[$];
  string       mMode;
  bit          mHostLast;
  bit          mArmed;
  bit          mRvPend;
  logic [31:0] mRvData;
  bit          mOvf;
  int          mWrCnt;
  logic [11:0] mAddrHold;
  logic [31:0] mWdataHold;
  logic [3:0]  mMaskHold;

  // Observations from the most recent cycle, for scenario-level checks
  logic obsGnt, obsFifoAcc, obsBusy, obsCsb;
  int   fullMaskWrites, hostGntCount;
  bit   progLevel;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    qAddr.delete();
    qData.delete();
    mMode      = "IDLE";
    mHostLast  = 1'b1;
    mArmed     = 1'b0;
    mRvPend    = 1'b0;
    mRvData    = '0;
    mOvf       = 1'b0;
    mWrCnt     = 0;
    mAddrHold  = '0;
    mWdataHold = '0;
    mMaskHold  = '0;
  endtask

  task automatic driveInputs(input bit prog, input bit pwWe, input logic [11:0] pwAddr,
                             input logic [31:0] pwData, input bit hReq, input bit hWe,
                             input logic [11:0] hAddr, input logic [31:0] hWdata,
                             input logic [3:0] hMask);
    bus.prog_i     = prog;
    bus.pw_we_i    = pwWe;
    bus.pw_addr_i  = pwAddr;
    bus.pw_wdata_i = pwData;
    bus.h_req_i    = hReq;
    bus.h_we_i     = hWe;
    bus.h_addr_i   = hAddr;
    bus.h_wdata_i  = hWdata;
    bus.h_wmask_i  = hMask;
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance the model
  task automatic applyStimulus(input bit prog, input bit pwWe, input logic [11:0] pwAddr,
                               input logic [31:0] pwData, input bit hReq, input bit hWe,
                               input logic [11:0] hAddr, input logic [31:0] hWdata,
                               input logic [3:0] hMask);
    bit          fifoHas;
    bit          gH;
    bit          gF;
    bit          newRv;
    logic [31:0] newRvData;
    logic [11:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expMask;
    driveInputs(prog, pwWe, pwAddr, pwData, hReq, hWe, hAddr, hWdata, hMask);
    #1;
    fifoHas = (qAddr.size() > 0);
    gH = 1'b0;
    gF = 1'b0;
    if (mArmed) begin
      if (mMode == "IDLE") begin
        if (hReq && fifoHas) begin
          if (mHostLast) gF = 1'b1;
          else           gH = 1'b1;
        end else if (hReq) gH = 1'b1;
        else if (fifoHas)  gF = 1'b1;
      end else begin
        gF = fifoHas;
      end
    end
    expAddr  = gH ? hAddr  : (gF ? qAddr[0] : mAddrHold);
    expWdata = gH ? hWdata : (gF ? qData[0] : mWdataHold);
    expMask  = gH ? hMask  : (gF ? 4'hF     : mMaskHold);

    checkOutput("h_gnt",   bus.h_gnt_o, gH);
    checkOutput("csb",     bus.csb_o, !(gH || gF));
    checkOutput("web",     bus.web_o, gH ? !hWe : !gF);
    checkOutput("addr",    bus.addr_o, expAddr);
    checkOutput("wdata",   bus.wdata_o, expWdata);
    checkOutput("wmask",   bus.wmask_o, expMask);
    checkOutput("h_rvalid", bus.h_rvalid_o, mRvPend);
    if (mRvPend) checkOutput("h_rdata", bus.h_rdata_o, mRvData);
    checkOutput("busy",    bus.busy_o, (mMode != "IDLE") || fifoHas);
    checkOutput("ovf",     bus.ovf_o, mOvf);
    checkOutput("wr_cnt",  bus.wr_cnt_o, mWrCnt);

    obsGnt     = bus.h_gnt_o;
    obsCsb     = bus.csb_o;
    obsBusy    = bus.busy_o;
    obsFifoAcc = (bus.csb_o === 1'b0) && (bus.h_gnt_o === 1'b0);
    if (bus.csb_o === 1'b0 && bus.web_o === 1'b0 && bus.wmask_o === 4'hF) fullMaskWrites++;
    if (bus.h_gnt_o === 1'b1) hostGntCount++;

    newRv     = 1'b0;
    newRvData = '0;
    if (gH) begin
      if (hWe) begin
        for (int b = 0; b < 4; b++)
          if (hMask[b]) refMem[hAddr][8*b +: 8] = hWdata[8*b +: 8];
      end else begin
        newRv     = 1'b1;
        newRvData = refMem[hAddr];
      end
      mAddrHold = hAddr; mWdataHold = hWdata; mMaskHold = hMask;
    end else if (gF) begin
      refMem[qAddr[0]] = qData[0];
      mAddrHold = qAddr[0]; mWdataHold = qData[0]; mMaskHold = 4'hF;
      void'(qAddr.pop_front());
      void'(qData.pop_front());
      if (mWrCnt < CNT_MAX) mWrCnt++;
    end
    if (pwWe) begin
      if (qAddr.size() < WDEPTH) begin
        qAddr.push_back(pwAddr);
        qData.push_back(pwData);
      end else begin
        mOvf = 1'b1;
      end
    end
    if (mMode == "IDLE" && (gH || gF)) mHostLast = gH;
    if (mMode == "IDLE") begin
      if (prog) begin mMode = "PROG"; mWrCnt = 0; end
    end else if (mMode == "PROG") begin
      if (!prog) mMode = "DRAIN";
    end else begin
      if (prog)          mMode = "PROG";
      else if (!fifoHas) mMode = "IDLE";
    end
    mRvPend = newRv;
    mRvData = newRvData;
    mArmed  = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset from mid-cycle, checked immediately, released at negedge
  task automatic doReset();
    driveInputs(0, 0, '0, '0, 0, 0, '0, '0, '0);
    rst = 1'b1;
    #1;
    checkOutput("rst_csb",    bus.csb_o, 1'b1);
    checkOutput("rst_web",    bus.web_o, 1'b1);
    checkOutput("rst_rvalid", bus.h_rvalid_o, 1'b0);
    checkOutput("rst_ovf",    bus.ovf_o, 1'b0);
    checkOutput("rst_wrcnt",  bus.wr_cnt_o, 0);
    checkOutput("rst_busy",   bus.busy_o, 1'b0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hostRead(input logic [11:0] a);
    applyStimulus(progLevel, 0, '0, '0, 1, 0, a, $urandom, 4'hF);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sramMem[i] = (i * 32'h9E3779B1) ^ 32'hA5C30F1E;
      refMem[i]  = sramMem[i];
    end
    bus.rdata_i    = '0;
    fullMaskWrites = 0;
    hostGntCount   = 0;
    progLevel      = 1'b0;
    $display("[TB] start");
    doReset();

    // Post-release cycle must not touch the SRAM even with a host request
    hostRead(12'h010);
    checkOutput("post_rst_noaccess", obsCsb, 1'b1);

    // Idle host read of 0x010 holding 0xDEADBEEF
    sramMem[12'h010] = 32'hDEADBEEF;
    refMem[12'h010]  = 32'hDEADBEEF;
    hostRead(12'h010);
    checkOutput("rd_gnt_same_cycle", obsGnt, 1'b1);
    checkOutput("rd_rvalid_next", bus.h_rvalid_o, 1'b1);
    checkOutput("rd_rdata_next", bus.h_rdata_o, 32'hDEADBEEF);
    applyStimulus(0, 0, '0, '0, 1, 1, 12'h011, 32'h12345678, 4'h3);
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, '0);
    checkOutput("wr_no_rvalid", bus.h_rvalid_o, 1'b0);

    // Programming session of four loader writes with the host locked out
    fullMaskWrites = 0;
    hostGntCount   = 0;
    applyStimulus(1, 0, '0, '0, 0, 0, '0, '0, '0);
    for (int k = 0; k < 4; k++)
      applyStimulus(1, 1, 12'(k), $urandom, 1, 0, 12'(k + 8), '0, 4'hF);
    applyStimulus(1, 0, '0, '0, 1, 0, 12'h020, '0, 4'hF);
    applyStimulus(1, 0, '0, '0, 1, 0, 12'h021, '0, 4'hF);
    checkOutput("prog_writes", fullMaskWrites, 4);
    checkOutput("prog_wrcnt", bus.wr_cnt_o, 4);
    checkOutput("prog_ovf", bus.ovf_o, 1'b0);
    checkOutput("prog_host_locked", hostGntCount, 0);
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, '0);
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, '0);

    // Round robin from the reset pointer, overflow, then a drain
    doReset();
    applyStimulus(0, 1, 12'h100, $urandom, 0, 0, '0, '0, '0);
    applyStimulus(0, 1, 12'h101, $urandom, 1, 0, 12'h010, '0, 4'hF);
    checkOutput("rr1_fifo", obsFifoAcc, 1'b1);
    checkOutput("rr1_host", obsGnt, 1'b0);
    applyStimulus(0, 1, 12'h102, $urandom, 1, 0, 12'h011, '0, 4'hF);
    checkOutput("rr2_host", obsGnt, 1'b1);
    applyStimulus(0, 1, 12'h103, $urandom, 1, 0, 12'h012, '0, 4'hF);
    checkOutput("rr3_fifo", obsFifoAcc, 1'b1);
    checkOutput("rr3_host", obsGnt, 1'b0);
    applyStimulus(0, 1, 12'h104, $urandom, 1, 0, 12'h013, '0, 4'hF);
    checkOutput("rr4_host", obsGnt, 1'b1);
    checkOutput("ovf_set", bus.ovf_o, 1'b1);
    applyStimulus(1, 1, 12'h105, $urandom, 0, 0, '0, '0, '0);
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, '0);
    applyStimulus(0, 0, '0, '0, 1, 0, 12'h030, '0, 4'hF);
    checkOutput("drain1_busy", obsBusy, 1'b1);
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, '0);
    checkOutput("drain2_busy", obsBusy, 1'b1);
    checkOutput("idle_busy", bus.busy_o, 1'b0);
    checkOutput("ovf_sticky", bus.ovf_o, 1'b1);
    hostRead(12'h102);
    checkOutput("idle_again_gnt", obsGnt, 1'b1);

    // Reset hitting just after a host read grant
    driveInputs(0, 0, '0, '0, 1, 0, 12'h020, '0, 4'hF);
    #1;
    checkOutput("rstrd_gnt", bus.h_gnt_o, 1'b1);
    #1;
    doReset();
    checkOutput("rstrd_rvalid", bus.h_rvalid_o, 1'b0);
    checkOutput("rstrd_busy", bus.busy_o, 1'b0);
    hostRead(12'h020);
    checkOutput("rstrd_noaccess", obsCsb, 1'b1);

    // Random traffic against the model, with one reset in the middle
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(9) == 0) progLevel = !progLevel;
      if (n == 200) doReset();
      applyStimulus(progLevel, 1'($urandom_range(1)), 12'($urandom_range(31)), $urandom,
                    1'($urandom_range(1)), 1'($urandom_range(1)), 12'($urandom_range(31)),
                    $urandom, 4'($urandom_range(15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
